// File: rtl/mult_err_sweep_ctrl.sv
// mult_err_sweep_ctrl
//   Error-characterisation sweep for an N x N combinational (approximate)
//   multiplier. Every operand pair (a outer, b inner) is presented on
//   mult_a/mult_b, one pair per cycle. The returned mult_y is registered
//   together with the exact product, then reduced into raw error terms.
//   The terms are: mismatch count, sum of error distances, sum of squared
//   errors, and the worst error with the operands that first reached it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin/restart a sweep (honoured in IDLE and DONE)
//   abort      end a running sweep (honoured in SWEEP and DRAIN)
//   mult_a/b   registered operands to the multiplier under test
//   mult_y     product returned by the multiplier under test
//   busy       high while sweeping or draining
//   done       high once a full sweep has completed, until restart/reset
//   err_count  pairs with mult_y != a*b
//   sum_ed     sum of |mult_y - a*b|
//   sum_sq     sum of (mult_y - a*b)^2
//   max_ed     largest error distance seen
//   max_a/b    operands of the first pair that reached max_ed
module mult_err_sweep_ctrl #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N-1:0]     mult_a,
  output logic [N-1:0]     mult_b,
  input  logic [2*N-1:0]   mult_y,
  output logic             busy,
  output logic             done,
  output logic [2*N:0]     err_count,
  output logic [4*N-1:0]   sum_ed,
  output logic [6*N-1:0]   sum_sq,
  output logic [2*N-1:0]   max_ed,
  output logic [N-1:0]     max_a,
  output logic [N-1:0]     max_b
);

  localparam int PW = 2 * N;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   idx;

  logic [PW-1:0]   y_p1;
  logic [PW-1:0]   exact_p1;
  logic [N-1:0]    a_p1;
  logic [N-1:0]    b_p1;
  logic            vld_p1;

  logic [PW-1:0]   exact_p0;
  logic [PW-1:0]   ed_p1;
  logic [2*PW-1:0] sq_p1;
  logic            abort_act;

  // |y - e| computed on a sign-extended difference so the magnitude is exact.
  function automatic logic [PW-1:0] abs_err(input logic [PW-1:0] y,
                                            input logic [PW-1:0] e);
    logic signed [PW:0] d;
    logic signed [PW:0] m;
    d = $signed({1'b0, y}) - $signed({1'b0, e});
    m = (d < 0) ? -d : d;
    return m[PW-1:0];
  endfunction

  // The operand registers are the sweep index itself.
  assign mult_a = idx[PW-1:N];
  assign mult_b = idx[N-1:0];

  // Stage 0: exact reference product for the pair currently presented
  assign exact_p0 = {{N{1'b0}}, mult_a} * {{N{1'b0}}, mult_b};

  // Stage 1 -> 2: error distance of the captured pair
  assign ed_p1 = abs_err(y_p1, exact_p1);
  assign sq_p1 = {{PW{1'b0}}, ed_p1} * {{PW{1'b0}}, ed_p1};

  // An abort discards the pair sitting in stage 1 rather than accumulating it.
  assign abort_act = abort && (state == SWEEP || state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vld_p1    <= 1'b0;
      y_p1      <= '0;
      exact_p1  <= '0;
      a_p1      <= '0;
      b_p1      <= '0;
      err_count <= '0;
      sum_ed    <= '0;
      sum_sq    <= '0;
      max_ed    <= '0;
      max_a     <= '0;
      max_b     <= '0;
    end else begin
      // Stage 2: accumulate error terms; strict compare keeps the first worst pair
      if (vld_p1 && !abort_act) begin
        err_count <= err_count + {{PW{1'b0}}, (ed_p1 != '0)};
        sum_ed    <= sum_ed + {{PW{1'b0}}, ed_p1};
        sum_sq    <= sum_sq + {{PW{1'b0}}, sq_p1};
        if (ed_p1 > max_ed) begin
          max_ed <= ed_p1;
          max_a  <= a_p1;
          max_b  <= b_p1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SWEEP;
            idx       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_count <= '0;
            sum_ed    <= '0;
            sum_sq    <= '0;
            max_ed    <= '0;
            max_a     <= '0;
            max_b     <= '0;
          end
        end

        SWEEP: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            vld_p1 <= 1'b0;
          end else begin
            // Stage 1: capture the pair presented during the last cycle
            y_p1     <= mult_y;
            exact_p1 <= exact_p0;
            a_p1     <= mult_a;
            b_p1     <= mult_b;
            vld_p1   <= 1'b1;
            // The last pair leaves the operands parked on their final value.
            if (&idx) state <= DRAIN;
            else      idx   <= idx + 1'b1;
          end
        end

        DRAIN: begin
          vld_p1 <= 1'b0;
          busy   <= 1'b0;
          if (abort) begin
            state <= IDLE;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_err_sweep_ctrl.sv
// Bench for mult_err_sweep_ctrl (N=4). A behavioural multiplier stub is
// selectable between exact, all-zero and LSB-flipped products. Each run
// pushes its expected end-of-run record; a monitor pops it when busy falls.
module tb_mult_err_sweep_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [3:0]   mult_a, mult_b;
  logic [7:0]   mult_y;
  logic         busy, done;
  logic [8:0]   err_count;
  logic [15:0]  sum_ed;
  logic [23:0]  sum_sq;
  logic [7:0]   max_ed;
  logic [3:0]   max_a, max_b;

  int mode = 0;  // 0 exact, 1 zero, 2 exact xor 1
  int checks = 0;
  int failures = 0;
  int dur = 0;
  bit prev_busy = 1'b0;
  bit ignore_fall = 1'b0;

  typedef struct {
    string name;
    int    done_v;
    int    dur_v;
    int    errc;
    int    sed;
    int    ssq;
    int    med;
    int    ma;
    int    mb;
  } exp_t;

  exp_t q[$];

  mult_err_sweep_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mult_a(mult_a), .mult_b(mult_b), .mult_y(mult_y),
    .busy(busy), .done(done), .err_count(err_count),
    .sum_ed(sum_ed), .sum_sq(sum_sq), .max_ed(max_ed),
    .max_a(max_a), .max_b(max_b)
  );

  always #5 clk = ~clk;

  logic [7:0] prod;
  always_comb begin
    prod = {4'b0, mult_a} * {4'b0, mult_b};
    mult_y = prod;
    if (mode == 1) mult_y = 8'd0;
    else if (mode == 2) mult_y = prod ^ 8'd1;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: one record per end of run (busy falling).
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_busy = 1'b0;
      dur = 0;
    end else begin
      if (busy) dur++;
      else if (prev_busy) begin
        if (ignore_fall) ignore_fall = 1'b0;
        else if (q.size() == 0) chk("unexpected_run_end", 1, 0);
        else begin
          e = q.pop_front();
          chk({e.name, ".done"},      int'(done),      e.done_v);
          chk({e.name, ".busy_cyc"},  dur,             e.dur_v);
          chk({e.name, ".err_count"}, int'(err_count), e.errc);
          chk({e.name, ".sum_ed"},    int'(sum_ed),    e.sed);
          chk({e.name, ".sum_sq"},    int'(sum_sq),    e.ssq);
          chk({e.name, ".max_ed"},    int'(max_ed),    e.med);
          chk({e.name, ".max_a"},     int'(max_a),     e.ma);
          chk({e.name, ".max_b"},     int'(max_b),     e.mb);
        end
        dur = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic push(input string nm, input int dn, input int du, input int ec,
                      input int se, input int sq, input int me, input int ma,
                      input int mb);
    exp_t e;
    e.name = nm; e.done_v = dn; e.dur_v = du; e.errc = ec; e.sed = se;
    e.ssq = sq; e.med = me; e.ma = ma; e.mb = mb;
    q.push_back(e);
  endtask

  // Leaves the caller at the falling edge just after the start-sampling edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk({nm, ".timeout"}, n, 0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, ".busy"},      int'(busy),      0);
    chk({nm, ".done"},      int'(done),      0);
    chk({nm, ".mult_ab"},   int'({mult_a, mult_b}), 0);
    chk({nm, ".err_count"}, int'(err_count), 0);
    chk({nm, ".sum_ed"},    int'(sum_ed),    0);
    chk({nm, ".sum_sq"},    int'(sum_sq),    0);
    chk({nm, ".max_ed"},    int'(max_ed),    0);
    chk({nm, ".max_abab"},  int'({max_a, max_b}), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Exact multiplier: no errors, done after 257 busy cycles.
    mode = 0;
    push("exact", 1, 257, 0, 0, 0, 0, 0, 0);
    pulse_start();
    wait_idle("exact");
    repeat (3) @(negedge clk);
    chk("exact.done_holds", int'(done), 1);

    // Restart with start held high; the zero-product stub takes effect.
    mode = 1;
    push("restart_zero", 1, 257, 225, 14400, 1537600, 225, 15, 15);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("restart.sum_ed_cleared", int'(sum_ed), 0);
    chk("restart.done_cleared", int'(done), 0);
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_idle("restart_zero");

    // LSB-flipped product: every pair errs by 1; first pair keeps the max.
    mode = 2;
    push("xor1", 1, 257, 256, 256, 256, 1, 0, 0);
    pulse_start();
    wait_idle("xor1");

    // Abort after 10 captured pairs: pairs 0..8 accumulated, all a=0.
    mode = 1;
    push("abort10", 0, 11, 0, 0, 0, 0, 0, 0);
    pulse_start();
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("abort10");

    // Abort after 21 captured pairs: pairs 0..19 accumulated;
    // (1,1),(1,2),(1,3) give ed 1,2,3.
    push("abort20", 0, 22, 3, 6, 14, 3, 1, 3);
    pulse_start();
    repeat (21) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("abort20");

    // Asynchronous reset at idx=100, checked before any further clock edge.
    pulse_start();
    repeat (100) @(negedge clk);
    chk("midrst.idx", int'({mult_a, mult_b}), 100);
    chk("midrst.busy_before", int'(busy), 1);
    #2;
    ignore_fall = 1'b1;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    #1;
    rst = 1'b0;
    wait_idle("post_reset_idle");

    push("after_reset_zero", 1, 257, 225, 14400, 1537600, 225, 15, 15);
    pulse_start();
    wait_idle("after_reset_zero");

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
